iterative_multiplier: RTL and testbench

ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

---
 rtl/kgp_mult_pkg.sv | 16 +
 rtl/mult_sign_fix.sv | 21 ++
 rtl/iterative_multiplier.sv | 127 ++++++++++++
 tb/tb_iterative_multiplier.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/kgp_mult_pkg.sv
// Shared types and opcodes for the iterative shift-add multiplier.
package kgp_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ALU_MULT_U = 4'b0001;
    localparam logic [3:0] ALU_MULT_S = 4'b0010;

    // Wide enough to hold 32 iterations when one bit is retired per cycle.
    localparam int CNT_W = 6;

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational sign handling for signed multiply: operand magnitudes on the way in,
// conditional two's-complement negation of the 64-bit product on the way out.
module mult_sign_fix (
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        negate,
    input  logic [63:0] product,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    output logic        negate_start,
    output logic [63:0] product_fix
);

    // 0x80000000 maps to itself, which reads correctly as the unsigned magnitude 2^31.
    assign mag_a        = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign mag_b        = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    assign negate_start = is_signed && (op_a[31] ^ op_b[31]);
    assign product_fix  = negate ? (~product + 64'd1) : product;

endmodule

// File: rtl/iterative_multiplier.sv
// Iterative shift-add 32x32->64 multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Define MULT_SIGNED_EN to build in signed multiply support for opcode 4'b0010.
module iterative_multiplier #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  alu_control,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        wren,
    output logic [3:0]  alu_control_out,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1
);
    import kgp_mult_pkg::*;

    localparam int CYCLES = 32 / BITS_PER_CYCLE;

    state_t            state;
    state_t            state_next;
    logic [63:0]       acc;
    logic [63:0]       acc_next;
    logic [63:0]       partial;
    logic [63:0]       mcand;
    logic [63:0]       result;
    logic [31:0]       mplier;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;
    logic [CNT_W-1:0]  count;
    logic [3:0]        op_reg;
    logic              accept;

    assign accept = start && ((alu_control == ALU_MULT_U) || (alu_control == ALU_MULT_S));

`ifdef MULT_SIGNED_EN
    logic negate;
    logic negate_start;

    mult_sign_fix u_sign_fix (
        .is_signed    (alu_control == ALU_MULT_S),
        .op_a         (op_a),
        .op_b         (op_b),
        .negate       (negate),
        .product      (acc_next),
        .mag_a        (mag_a),
        .mag_b        (mag_b),
        .negate_start (negate_start),
        .product_fix  (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            negate <= 1'b0;
        end else if (state == IDLE && accept) begin
            negate <= negate_start;
        end
    end
`else
    assign mag_a  = op_a;
    assign mag_b  = op_b;
    assign result = acc_next;
`endif

    // Weighted sum of the multiplicand for the multiplier bits retired this cycle.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
        acc_next = acc + partial;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            count           <= '0;
            op_reg          <= '0;
            alu_control_out <= '0;
            wdata0          <= '0;
            wdata1          <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                acc    <= '0;
                mcand  <= {32'd0, mag_a};
                mplier <= mag_b;
                count  <= CNT_W'(CYCLES);
                op_reg <= alu_control;
            end else if (state == RUN) begin
                acc    <= acc_next;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                count  <= count - CNT_W'(1);
                // Final iteration: publish the completed product as DONE is entered.
                if (count == CNT_W'(1)) begin
                    wdata0          <= result[31:0];
                    wdata1          <= result[63:32];
                    alu_control_out <= op_reg;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign wren = done;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench: two multipliers (1 and 2 bits per cycle) driven in parallel
// against a plain-arithmetic product model. Honours MULT_SIGNED_EN like the RTL.
module tb_iterative_multiplier;
    import kgp_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        busy1, done1, wren1;
    logic [3:0]  aco1;
    logic [31:0] wd0_1, wd1_1;
    logic        busy2, done2, wren2;
    logic [3:0]  aco2;
    logic [31:0] wd0_2, wd1_2;

    int checks = 0;
    int errors = 0;
    int pulses1;
    int pulses2;

    iterative_multiplier #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1), .wren(wren1),
        .alu_control_out(aco1), .wdata0(wd0_1), .wdata1(wd1_1)
    );

    iterative_multiplier #(.BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .busy(busy2), .done(done2), .wren(wren2),
        .alu_control_out(aco2), .wdata0(wd0_2), .wdata1(wd1_2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        if (op == ALU_MULT_S) begin
            return 64'(longint'($signed(a)) * longint'($signed(b)));
        end
`endif
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Issues one multiply and follows both DUTs until the slower one is back in IDLE.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [63:0] expected;
        expected    = refProduct(op, a, b);
        alu_control = op;
        op_a        = a;
        op_b        = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pulses1 = 0;
        pulses2 = 0;
        for (int k = 1; k <= 33; k++) begin
            op_a        = $urandom;
            op_b        = $urandom;
            alu_control = 4'($urandom);
            start       = 1'b0;
            if (inject && k == 5) begin
                alu_control = ALU_MULT_U;
                start       = 1'b1;
            end
            @(posedge clk);
            #1;
            if (wren1) pulses1++;
            if (wren2) pulses2++;
            checkOutput("done1", done1, k == 32);
            checkOutput("wren1", wren1, k == 32);
            checkOutput("busy1", busy1, k <= 32);
            checkOutput("done2", done2, k == 16);
            checkOutput("wren2", wren2, k == 16);
            checkOutput("busy2", busy2, k <= 16);
            if (k == 32) begin
                checkOutput("product1", {wd1_1, wd0_1}, expected);
                checkOutput("opcode1", aco1, op);
            end
            if (k == 16 || k == 33) begin
                checkOutput("product2", {wd1_2, wd0_2}, expected);
                checkOutput("opcode2", aco2, op);
            end
        end
        start = 1'b0;
        checkOutput("pulses1", pulses1, 1);
        checkOutput("pulses2", pulses2, 1);
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        rst         = 1'b1;
        start       = 1'b0;
        alu_control = 4'd0;
        op_a        = 32'd0;
        op_b        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {busy1, busy2}, 2'b00);
        checkOutput("reset_done", {done1, done2, wren1, wren2}, 4'b0000);
        checkOutput("reset_data1", {aco1, wd1_1, wd0_1}, 68'd0);
        checkOutput("reset_data2", {aco2, wd1_2, wd0_2}, 68'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(ALU_MULT_U, 32'd3, 32'd5, 1'b0);
        checkOutput("dir_3x5", {wd1_1, wd0_1}, 64'h0000_0000_0000_000F);

        applyStimulus(ALU_MULT_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("dir_max_1", {wd1_1, wd0_1}, 64'hFFFF_FFFE_0000_0001);
        checkOutput("dir_max_2", {wd1_2, wd0_2}, 64'hFFFF_FFFE_0000_0001);

        applyStimulus(ALU_MULT_S, 32'hFFFF_FFFE, 32'd3, 1'b0);
`ifdef MULT_SIGNED_EN
        checkOutput("dir_neg2x3", {wd1_1, wd0_1}, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        checkOutput("dir_neg2x3", {wd1_1, wd0_1}, 64'h0000_0002_FFFF_FFFA);
`endif
        checkOutput("dir_opcode_s", aco1, 4'b0010);

        applyStimulus(ALU_MULT_S, 32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("dir_minmin", {wd1_1, wd0_1}, 64'h4000_0000_0000_0000);

        // A second start during RUN must be dropped.
        applyStimulus(ALU_MULT_U, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checkOutput("dir_inject", {wd1_1, wd0_1}, 64'h0B00_EA4E_242D_2080);

        // Unsupported opcode in IDLE: nothing starts, outputs hold.
        held        = {wd1_1, wd0_1};
        alu_control = 4'b0100;
        op_a        = 32'd7;
        op_b        = 32'd7;
        start       = 1'b1;
        pulses1     = 0;
        pulses2     = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (wren1) pulses1++;
            if (wren2) pulses2++;
            if (busy1 || busy2) pulses1++;
        end
        checkOutput("badop_pulses", pulses1 + pulses2, 0);
        checkOutput("badop_hold", {wd1_1, wd0_1}, held);

        // Reset ten cycles into RUN aborts without a write.
        alu_control = ALU_MULT_U;
        op_a        = 32'hDEAD_BEEF;
        op_b        = 32'h0000_0101;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("pre_abort_busy", {busy1, busy2}, 2'b11);
        rst = 1'b1;
        #1;
        checkOutput("abort_ctl", {busy1, busy2, done1, done2, wren1, wren2}, 6'd0);
        checkOutput("abort_data1", {aco1, wd1_1, wd0_1}, 68'd0);
        checkOutput("abort_data2", {aco2, wd1_2, wd0_2}, 68'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        pulses1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (wren1 || wren2 || busy1 || busy2) pulses1++;
        end
        checkOutput("abort_no_wren", pulses1, 0);
        applyStimulus(ALU_MULT_U, 32'd7, 32'd9, 1'b0);
        checkOutput("dir_7x9", {wd1_1, wd0_1}, 64'h0000_0000_0000_003F);

        for (int n = 0; n < 24; n++) begin
            rop = ($urandom_range(0, 1) == 0) ? ALU_MULT_U : ALU_MULT_S;
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'd0;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            applyStimulus(rop, ra, rb, n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
